instruction_fetch: RTL

Pipeline IF stage plus the IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and applies redirects in priority order: exception/eret, stall, taken branch/jump from ID, sequential. Detects misaligned or out-of-range fetch addresses (AdEL), marks delay-slot instructions (BD), and registers instruction, PC+4 and exception fields for the decode stage.

---
 rtl/instruction_fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_if_id_register.sv | 23 ++
 rtl/instruction_fetch.sv | 99 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage types and constants: reset/handler PCs, fetch window, exception codes.
// Latency: n/a (package). Backpressure: n/a.
// Optional IF_ADDR_CHECK_EN (used by instruction_fetch) enables AdEL fetch checks.
package instruction_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] IM_LOW_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_HIGH_DEF  = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] epc;
        logic        exception;
        logic [4:0]  exc_code;
        logic        bd;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: clear (bubble) beats hold, hold beats load.
// Latency: 1 cycle. Backpressure: hold freezes the current entry.
// Reset is folded into clear by the parent so this block stays a plain register.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   clear,
    input  logic   hold,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= IF_ID_BUBBLE;
        end else if (load && !hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, prioritised next-PC mux, AdEL check (IF_ADDR_CHECK_EN) and IF/ID register.
// Latency: im_addr combinational from PC; IF/ID outputs one cycle after the fetch.
// Backpressure: stall holds PC and IF/ID; redirect and reset override stall.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_LOW   = IM_LOW_DEF,
    parameter logic [31:0] IM_HIGH  = IM_HIGH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        PC_jump,
    input  logic [31:0] NPC_target,
    input  logic        has_delay_slot,
    input  logic        nullify_delay_slot,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] Inst,
    output logic [31:0] PC4,
    output logic [31:0] EPC,
    output logic        exception,
    output logic [4:0]  ExcCode,
    output logic        BD
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        fetch_fault;
    logic        if_id_clear;
    logic        if_id_hold;
    logic        if_id_load;
    if_id_t      if_entry;
    if_id_t      if_id_q;

    assign im_addr  = pc;
    assign pc_plus4 = pc + 32'd4;

`ifdef IF_ADDR_CHECK_EN
    assign fetch_fault = (pc[1:0] != 2'b00) || (pc < IM_LOW) || (pc > IM_HIGH);
`else
    logic addr_bounds_unused;
    assign addr_bounds_unused = ^{IM_LOW, IM_HIGH};
    assign fetch_fault        = 1'b0;
`endif

    always_comb begin
        if_entry           = IF_ID_BUBBLE;
        if_entry.inst      = fetch_fault ? 32'd0 : im_data;
        if_entry.pc4       = pc_plus4;
        if_entry.epc       = has_delay_slot ? (pc - 32'd4) : pc;
        if_entry.exception = fetch_fault;
        if_entry.exc_code  = fetch_fault ? EXC_ADEL : EXC_NONE;
        if_entry.bd        = has_delay_slot;
    end

    // A faulting fetch still advances; CP0 redirects to the handler afterwards.
    always_comb begin
        pc_next = pc_plus4;
        if (reset) begin
            pc_next = PC_RESET;
        end else if (redirect) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc;
        end else if (PC_jump) begin
            pc_next = NPC_target;
        end
    end

    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    assign if_id_clear = reset || redirect || (!stall && nullify_delay_slot);
    assign if_id_hold  = stall;
    assign if_id_load  = !stall;

    if_id_register u_if_id (
        .clk   (clk),
        .clear (if_id_clear),
        .hold  (if_id_hold),
        .load  (if_id_load),
        .d     (if_entry),
        .q     (if_id_q)
    );

    assign Inst      = if_id_q.inst;
    assign PC4       = if_id_q.pc4;
    assign EPC       = if_id_q.epc;
    assign exception = if_id_q.exception;
    assign ExcCode   = if_id_q.exc_code;
    assign BD        = if_id_q.bd;

endmodule
